// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the MIPS fetch path.
//
// Owns the program counter and fetches one word at a time from instruction
// memory over a req/ack handshake. It holds each fetched word until decode
// accepts it (instr_valid && !stall). On acceptance it loads the next PC
// from jr_target, the jump target, the branch target or PC+4, in that order
// of priority. Redirects take effect with no delay slot.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a misaligned jr target traps into a sticky error state
//               (addr_error=1, no further fetches until rst).
//   undefined : jr_target[1:0] are forced to 0 and addr_error is tied to 0.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address (the current PC)
//   imem_ack      memory completes the fetch this cycle
//   imem_rdata    instruction word returned with imem_ack
//   instr_valid   instr/instr_pc hold a fetched instruction
//   instr         fetched instruction word
//   instr_pc      address of instr
//   stall         decode not ready
//   jump          accepted instruction is J/JAL; jump_index is its index field
//   branch_taken  accepted instruction is a taken branch; branch_offset in words
//   jr            accepted instruction is JR/JALR; jr_target is the register
//   pc_plus4      instr_pc + 4 (link value)
//   addr_error    misaligned jr target trapped
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic        addr_error
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StFetch, StHold, StError} state_t;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_t;
`endif

  state_t      state;
  logic        accept;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_aligned;
  logic [31:0] next_pc;

  // imem_addr doubles as the PC register: it only changes on acceptance.
  assign pc_plus4 = instr_pc + 32'd4;
  assign accept   = (state == StHold) && !stall;

  always_comb begin
    branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    jr_aligned    = {jr_target[31:2], 2'b00};
    next_pc       = pc_plus4;
    if (jr) begin
      next_pc = jr_aligned;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  logic unused_jr_lsb;
  assign unused_jr_lsb = ^jr_target[1:0];
  assign addr_error    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Any outstanding fetch is dropped; an ack in this cycle is ignored.
      state       <= StIdle;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
      addr_error  <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          state    <= StFetch;
          imem_req <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= imem_addr;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= StHold;
          end
        end
        StHold: begin
          if (accept) begin
            instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (jr && (jr_target[1:0] != 2'b00)) begin
              state      <= StError;
              addr_error <= 1'b1;
            end else begin
              imem_addr <= next_pc;
              imem_req  <= 1'b1;
              state     <= StFetch;
            end
`else
            imem_addr <= next_pc;
            imem_req  <= 1'b1;
            state     <= StFetch;
`endif
          end
        end
`ifdef PC_ALIGN_CHECK_EN
        StError: begin
          // Sticky until rst.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          state    <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc_plus4;
  logic        addr_error;

  int checks = 0;
  int errors = 0;

  // Memory model: returns 0x2000_0000 + addr after lat wait cycles.
  int          lat = 0;
  int          cnt = 0;
  logic        ack_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign imem_ack   = (imem_req && (cnt >= lat)) || ack_force;
  assign imem_rdata = 32'h2000_0000 + imem_addr;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .stall        (stall),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc_plus4     (pc_plus4),
    .addr_error   (addr_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expect FETCH at addr (req high, no valid instruction).
  task automatic exp_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
  endtask

  // Expect HOLD with the instruction fetched from pc.
  task automatic exp_hold(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_ipc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, 32'h2000_0000 + pc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_index = '0; branch_taken = 1'b0;
    branch_offset = '0; jr = 1'b0; jr_target = '0;
    tick();
    tick();
    rst = 1'b0;
    // IDLE cycle: reset values
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_aerr", {31'b0, addr_error}, 32'd0);

    // Sequential stream, zero-wait memory
    tick(); exp_fetch("seq0", 32'h0);
    tick(); exp_hold("seq0h", 32'h0);
    tick(); exp_fetch("seq1", 32'h4);
    tick(); exp_hold("seq1h", 32'h4);
    tick(); exp_fetch("seq2", 32'h8);
    tick(); exp_hold("seq2h", 32'h8);

    // jr to 0x4000_0010
    jr = 1'b1; jr_target = 32'h4000_0010;
    tick(); exp_fetch("jr1", 32'h4000_0010);
    jr = 1'b0;
    tick(); exp_hold("jr1h", 32'h4000_0010);

    // Stall 3 cycles with redirects present but ignored
    stall = 1'b1; jump = 1'b1; jump_index = 26'h0000040; branch_taken = 1'b1;
    branch_offset = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_hold("stall", 32'h4000_0010);
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick(); exp_fetch("jump", 32'h4000_0100);
    jump = 1'b0;
    tick(); exp_hold("jumph", 32'h4000_0100);
    check("jump_pc4", pc_plus4, 32'h4000_0104);

    // Branches around 0x100
    jr = 1'b1; jr_target = 32'h100;
    tick(); exp_fetch("jr2", 32'h100);
    jr = 1'b0;
    tick(); exp_hold("jr2h", 32'h100);
    branch_taken = 1'b1; branch_offset = 16'hFFFE;
    tick(); exp_fetch("br_neg", 32'h0FC);
    branch_taken = 1'b0;
    tick(); exp_hold("br_negh", 32'h0FC);
    jr = 1'b1; jr_target = 32'h100;
    tick(); exp_fetch("jr3", 32'h100);
    jr = 1'b0;
    tick(); exp_hold("jr3h", 32'h100);
    branch_taken = 1'b1; branch_offset = 16'h0003;
    tick(); exp_fetch("br_pos", 32'h110);
    branch_taken = 1'b0;
    tick(); exp_hold("br_posh", 32'h110);

    // jr beats jump and branch
    jr = 1'b1; jr_target = 32'h200; jump = 1'b1; jump_index = 26'h3FFFFFF;
    branch_taken = 1'b1; branch_offset = 16'h0010;
    tick(); exp_fetch("prio", 32'h200);
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tick(); exp_hold("prioh", 32'h200);

    // Wrap at top of address space
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick(); exp_fetch("jrtop", 32'hFFFF_FFFC);
    jr = 1'b0;
    tick(); exp_hold("jrtoph", 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    tick(); exp_fetch("wrap", 32'h0);
    tick(); exp_hold("wraph", 32'h0);
    branch_taken = 1'b1; branch_offset = 16'hFFFE;
    tick(); exp_fetch("br_wrap", 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick(); exp_hold("br_wraph", 32'hFFFF_FFFC);

    // Misaligned jr target
    jr = 1'b1; jr_target = 32'h0000_0102;
    tick();
    jr = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("aerr", {31'b0, addr_error}, 32'd1);
      check("aerr_req", {31'b0, imem_req}, 32'd0);
      check("aerr_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
`else
    exp_fetch("jr_mis", 32'h100);
    check("aerr0", {31'b0, addr_error}, 32'd0);
`endif

    // Slow memory, reset during the second wait cycle
    lat = 4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_aerr", {31'b0, addr_error}, 32'd0);
    check("rst2_req", {31'b0, imem_req}, 32'd0);
    tick(); exp_fetch("slow_a", 32'h0);
    tick(); exp_fetch("slow_w2", 32'h0);
    rst = 1'b1; ack_force = 1'b1;
    tick();
    rst = 1'b0;
    // IDLE: ack still forced, must be ignored
    check("rst3_req", {31'b0, imem_req}, 32'd0);
    check("rst3_valid", {31'b0, instr_valid}, 32'd0);
    check("rst3_addr", imem_addr, 32'h0);
    tick();
    ack_force = 1'b0;
    exp_fetch("restart", 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_fetch("slow_wait", 32'h0);
    end
    tick(); exp_fetch("slow_ack", 32'h0);
    tick(); exp_hold("slowh", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
